// File: rtl/frame_write_packer.sv
// -----------------------------------------------------------------------------
// frame_write_packer
//
// Write side of the DRAM frame buffer. Packs PIXELS_PER_WORD consecutive
// camera pixels into one wide word and presents it as an AXI-stream beat
// carrying {word address, data, tlast}. A small output FIFO absorbs
// write-path backpressure. The camera is never stalled: words that cannot be
// queued, or that are missing pixels, are dropped and counted.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   pixel_valid_in  pixel_data_in / hcount_in / vcount_in valid this cycle
//   pixel_data_in   pixel value (PIXEL_WIDTH bits)
//   hcount_in       pixel column (11 bits)
//   vcount_in       pixel row (10 bits)
//   tready_in       downstream accepts the current word
//   tvalid_out      word available (FIFO non-empty)
//   tdata_out       packed pixels, lane k at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   addr_out        word address = (vcount*H_ACTIVE + hcount) / PIXELS_PER_WORD
//   tlast_out       high with the word whose address is FRAME_WORDS-1
//   overflow_out    1-cycle pulse when a completed word is dropped (FIFO full)
//   drop_count_out  total dropped words (overflow + incomplete), saturating
// -----------------------------------------------------------------------------
module frame_write_packer #(
    parameter int H_ACTIVE        = 1280,
    parameter int V_ACTIVE        = 720,
    parameter int PIXEL_WIDTH     = 16,
    parameter int PIXELS_PER_WORD = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   pixel_valid_in,
    input  logic [PIXEL_WIDTH-1:0]                 pixel_data_in,
    input  logic [10:0]                            hcount_in,
    input  logic [9:0]                             vcount_in,
    input  logic                                   tready_in,
    output logic                                   tvalid_out,
    output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] tdata_out,
    output logic [26:0]                            addr_out,
    output logic                                   tlast_out,
    output logic                                   overflow_out,
    output logic [15:0]                            drop_count_out
);

    localparam int LANE_W      = $clog2(PIXELS_PER_WORD);
    localparam int WORD_W      = PIXEL_WIDTH * PIXELS_PER_WORD;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / PIXELS_PER_WORD;

    localparam logic [11:0]    H_LIMIT   = 12'(H_ACTIVE);
    localparam logic [10:0]    V_LIMIT   = 11'(V_ACTIVE);
    localparam logic [26:0]    LAST_ADDR = 27'(FRAME_WORDS - 1);
    localparam logic [PTR_W:0] DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    // Packing state
    logic [PIXELS_PER_WORD-1:0] mask_q;
    logic [WORD_W-1:0]          pack_q;

    // FIFO state
    logic [WORD_W-1:0] fifo_data [FIFO_DEPTH];
    logic [26:0]       fifo_addr [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    // Status
    logic        overflow_q;
    logic [15:0] drop_q;

    // Combinational datapath
    logic [LANE_W-1:0]          lane;
    logic                       accept;
    logic                       word_done;
    logic                       mask_full;
    logic                       push_req;
    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic                       drop_ovf;
    logic                       drop_inc;
    logic [PIXELS_PER_WORD-1:0] mask_next;
    logic [WORD_W-1:0]          word_next;
    logic [26:0]                pixel_addr;

    // NOTE: every signal driven here gets a default before any conditional
    // update, so no path through the block leaves a value held (no latch).
    always_comb begin
        lane   = hcount_in[LANE_W-1:0];
        accept = pixel_valid_in
               && ({1'b0, hcount_in} < H_LIMIT)
               && ({1'b0, vcount_in} < V_LIMIT);

        // A lane-0 pixel starts a fresh word, so earlier mask bits are stale.
        mask_next       = (lane == '0) ? '0 : mask_q;
        mask_next[lane] = 1'b1;

        word_next = pack_q;
        word_next[32'(lane) * PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data_in;

        mask_full = &mask_next;
        word_done = accept && (&lane);
        push_req  = word_done && mask_full;

        pop       = tvalid_out && tready_in;
        fifo_full = (count_q == DEPTH_C);
        // A pop on the same edge frees the slot the new word lands in.
        push      = push_req && (!fifo_full || pop);
        drop_ovf  = push_req && fifo_full && !pop;
        drop_inc  = drop_ovf || (word_done && !mask_full);

        pixel_addr = (27'(vcount_in) * 27'(H_ACTIVE) + 27'(hcount_in)) >> LANE_W;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mask_q     <= '0;
            pack_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            overflow_q <= drop_ovf;

            if (accept) begin
                pack_q <= word_next;
                mask_q <= word_done ? '0 : mask_next;
            end

            if (drop_inc && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is tracked by count_q, and
    // the outputs are gated with tvalid_out so stale entries never appear.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= word_next;
            fifo_addr[wr_ptr_q] <= pixel_addr;
            fifo_last[wr_ptr_q] <= (pixel_addr == LAST_ADDR);
        end
    end

    always_comb begin
        tvalid_out     = (count_q != '0);
        tdata_out      = tvalid_out ? fifo_data[rd_ptr_q] : '0;
        addr_out       = tvalid_out ? fifo_addr[rd_ptr_q] : '0;
        tlast_out      = tvalid_out ? fifo_last[rd_ptr_q] : 1'b0;
        overflow_out   = overflow_q;
        drop_count_out = drop_q;
    end

endmodule

// File: tb/tb_frame_write_packer.sv
// -----------------------------------------------------------------------------
// tb_frame_write_packer
//
// Self-checking bench for frame_write_packer at the default 1280x720 geometry.
// A table of per-cycle vectors covers packing, ignored pixels, incomplete
// words and tlast; hand-written sequences cover reset, the start of a frame,
// backpressure/overflow, reset mid-word and a simultaneous pop and push on a
// full FIFO. Inputs are applied before a rising edge and outputs are sampled
// 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_frame_write_packer;

    localparam int H  = 1280;
    localparam int V  = 720;
    localparam int PW = 16;
    localparam int PP = 8;
    localparam int DW = PW * PP;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          pixel_valid_in = 1'b0;
    logic [PW-1:0] pixel_data_in = '0;
    logic [10:0]   hcount_in = '0;
    logic [9:0]    vcount_in = '0;
    logic          tready_in = 1'b0;
    logic          tvalid_out;
    logic [DW-1:0] tdata_out;
    logic [26:0]   addr_out;
    logic          tlast_out;
    logic          overflow_out;
    logic [15:0]   drop_count_out;

    int checks = 0;
    int errors = 0;

    frame_write_packer #(
        .H_ACTIVE       (H),
        .V_ACTIVE       (V),
        .PIXEL_WIDTH    (PW),
        .PIXELS_PER_WORD(PP),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .pixel_valid_in(pixel_valid_in),
        .pixel_data_in (pixel_data_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .tready_in     (tready_in),
        .tvalid_out    (tvalid_out),
        .tdata_out     (tdata_out),
        .addr_out      (addr_out),
        .tlast_out     (tlast_out),
        .overflow_out  (overflow_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic v;
        int   h;
        int   y;
        logic rdy;
        logic e_valid;
        int   e_addr;
        logic e_last;
        logic e_ovf;
        int   e_drop;
    } vec_t;

    vec_t vecs[$];

    // Distinct, position-derived pixel value.
    function automatic logic [PW-1:0] pix(input int h, input int y);
        return PW'(((y & 31) << 11) | (h & 2047));
    endfunction

    // Expected packed word for a given word address in a complete frame.
    function automatic logic [DW-1:0] word_data(input int a);
        logic [DW-1:0] d;
        int idx, x0, y0;
        idx = a * PP;
        y0  = idx / H;
        x0  = idx % H;
        d   = '0;
        for (int k = 0; k < PP; k++) d[k*PW +: PW] = pix(x0 + k, y0);
        return d;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input int h, input int y, input logic rdy);
        pixel_valid_in = v;
        hcount_in      = 11'(h);
        vcount_in      = 10'(y);
        pixel_data_in  = pix(h, y);
        tready_in      = rdy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_in = 1'b1;
        repeat (cycles) step(1'b0, 0, 0, 1'b0);
        rst_in = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " tvalid"},   DW'(tvalid_out),     '0);
        check({tag, " tdata"},    tdata_out,           '0);
        check({tag, " addr"},     DW'(addr_out),       '0);
        check({tag, " tlast"},    DW'(tlast_out),      '0);
        check({tag, " overflow"}, DW'(overflow_out),   '0);
        check({tag, " drops"},    DW'(drop_count_out), '0);
    endtask

    task automatic check_word(input string tag, input int a, input logic last);
        check({tag, " tvalid"}, DW'(tvalid_out), DW'(1));
        check({tag, " addr"},   DW'(addr_out),   DW'(a));
        check({tag, " tdata"},  tdata_out,       word_data(a));
        check({tag, " tlast"},  DW'(tlast_out),  DW'(last));
    endtask

    task automatic add(input logic v, input int h, input int y, input logic rdy,
                       input logic ev, input int ea, input logic el, input int ed);
        vec_t t;
        t.v = v; t.h = h; t.y = y; t.rdy = rdy;
        t.e_valid = ev; t.e_addr = ea; t.e_last = el; t.e_ovf = 1'b0; t.e_drop = ed;
        vecs.push_back(t);
    endtask

    int exp_addr;

    initial begin
        // ---------------- vector table ----------------
        // Word 321 (y=2, x=8..15) with out-of-range pixels interleaved.
        for (int x = 8; x <= 11; x++) add(1, x, 2, 1, 0, 0, 0, 0);
        add(1, 1280, 2,   1, 0, 0, 0, 0);
        add(1, 1287, 5,   1, 0, 0, 0, 0);
        add(1, 1288, 2,   1, 0, 0, 0, 0);
        add(1, 1290, 1,   1, 0, 0, 0, 0);
        add(1, 15,   720, 1, 0, 0, 0, 0);
        add(1, 8,    720, 1, 0, 0, 0, 0);
        add(0, 0,    2,   1, 0, 0, 0, 0);
        for (int x = 12; x <= 14; x++) add(1, x, 2, 1, 0, 0, 0, 0);
        add(1, 15, 2, 1, 1, 321, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        // Missing x=3 on y=0: word 0 dropped, word 1 delivered.
        for (int x = 0; x <= 6; x++) if (x != 3) add(1, x, 0, 1, 0, 0, 0, 0);
        add(1, 7, 0, 1, 0, 0, 0, 1);
        for (int x = 8; x <= 14; x++) add(1, x, 0, 1, 0, 0, 0, 1);
        add(1, 15, 0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        // Last two words of the frame: tlast only on 115199.
        for (int x = 1264; x <= 1270; x++) add(1, x, 719, 1, 0, 0, 0, 1);
        add(1, 1271, 719, 1, 1, 115198, 0, 1);
        for (int x = 1272; x <= 1278; x++) add(1, x, 719, 1, 0, 0, 0, 1);
        add(1, 1279, 719, 1, 1, 115199, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1);

        // ---------------- reset ----------------
        do_reset(3);
        check_reset_state("reset");

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].h, vecs[i].y, vecs[i].rdy);
            check($sformatf("vec%0d tvalid", i), DW'(tvalid_out), DW'(vecs[i].e_valid));
            check($sformatf("vec%0d overflow", i), DW'(overflow_out), DW'(vecs[i].e_ovf));
            check($sformatf("vec%0d drops", i), DW'(drop_count_out), DW'(vecs[i].e_drop));
            if (vecs[i].e_valid)
                check_word($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_last);
        end

        // ---------------- frame start: two full lines ----------------
        do_reset(3);
        exp_addr = 0;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < H; x++) begin
                step(1, x, y, 1);
                if ((x % PP) == PP - 1) begin
                    check_word($sformatf("frame w%0d", exp_addr), exp_addr, 1'b0);
                    exp_addr++;
                end
            end
        end
        step(0, 0, 0, 1);
        check("frame idle tvalid", DW'(tvalid_out), '0);
        check("frame drops", DW'(drop_count_out), '0);

        // ---------------- backpressure / overflow ----------------
        do_reset(3);
        for (int x = 0; x < 40; x++) begin
            step(1, x, 3, 0);
            if (x == 31) begin
                check_word("bp held4", 480, 1'b0);
                check("bp no ovf yet", DW'(overflow_out), '0);
                check("bp no drop yet", DW'(drop_count_out), '0);
            end
        end
        check("bp overflow pulse", DW'(overflow_out), DW'(1));
        check("bp drop1", DW'(drop_count_out), DW'(1));
        check_word("bp head stable", 480, 1'b0);
        step(0, 0, 0, 0);
        check("bp overflow once", DW'(overflow_out), '0);
        for (int i = 0; i < 4; i++) begin
            check_word($sformatf("bp drain%0d", i), 480 + i, 1'b0);
            step(0, 0, 0, 1);
        end
        check("bp empty", DW'(tvalid_out), '0);
        check("bp drop kept", DW'(drop_count_out), DW'(1));

        // Reset while the FIFO holds a word.
        for (int x = 0; x < 8; x++) step(1, x, 6, 0);
        check_word("prereset word", 960, 1'b0);
        do_reset(3);
        check_reset_state("reset full");

        // ---------------- reset mid-word ----------------
        for (int x = 0; x <= 4; x++) step(1, x, 4, 1);
        do_reset(1);
        check("midrst tvalid", DW'(tvalid_out), '0);
        for (int x = 5; x <= 7; x++) begin
            step(1, x, 4, 1);
            check($sformatf("midrst x%0d tvalid", x), DW'(tvalid_out), '0);
        end
        check("midrst partial dropped", DW'(drop_count_out), DW'(1));
        for (int x = 8; x <= 15; x++) step(1, x, 4, 1);
        check_word("midrst next word", 641, 1'b0);
        check("midrst drops", DW'(drop_count_out), DW'(1));

        // ---------------- full FIFO, pop and push together ----------------
        do_reset(3);
        for (int x = 0; x < 39; x++) step(1, x, 5, 0);
        check_word("simul full head", 800, 1'b0);
        step(1, 39, 5, 1);
        check("simul no overflow", DW'(overflow_out), '0);
        check("simul no drop", DW'(drop_count_out), '0);
        for (int i = 0; i < 4; i++) begin
            check_word($sformatf("simul drain%0d", i), 801 + i, 1'b0);
            step(0, 0, 0, 1);
        end
        check("simul empty", DW'(tvalid_out), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
